// File: rtl/regfile_arbiter.sv
// Two-client round-robin sequencer for the 16x16 register file.
// Each command runs IDLE -> ISSUE -> CAPTURE; read data and done come back registered.
module regfile_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  rw0,
    input  logic [1:0]  rw1,
    input  logic [3:0]  da0,
    input  logic [3:0]  da1,
    input  logic [3:0]  aa0,
    input  logic [3:0]  aa1,
    input  logic [3:0]  ba0,
    input  logic [3:0]  ba1,
    input  logic [15:0] d0,
    input  logic [15:0] d1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rd_a,
    output logic [15:0] rd_b,
    output logic        busy,
    output logic        rf_en,
    output logic [1:0]  rf_rw,
    output logic [3:0]  rf_da,
    output logic [3:0]  rf_aa,
    output logic [3:0]  rf_ba,
    output logic [15:0] rf_d,
    input  logic [15:0] rf_a,
    input  logic [15:0] rf_b
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StCapture = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_last, w_last_next;
    logic [1:0]  r_cmd_rw, w_cmd_rw_next;
    logic        r_gnt0, w_gnt0_next;
    logic        r_gnt1, w_gnt1_next;
    logic        r_done0, w_done0_next;
    logic        r_done1, w_done1_next;
    logic [15:0] r_rd_a, w_rd_a_next;
    logic [15:0] r_rd_b, w_rd_b_next;
    logic        r_busy, w_busy_next;
    logic        r_rf_en, w_rf_en_next;
    logic [1:0]  r_rf_rw, w_rf_rw_next;
    logic [3:0]  r_rf_da, w_rf_da_next;
    logic [3:0]  r_rf_aa, w_rf_aa_next;
    logic [3:0]  r_rf_ba, w_rf_ba_next;
    logic [15:0] r_rf_d, w_rf_d_next;
    logic        w_pick1;

    // On a tie, client 1 wins only if client 0 was granted last.
    assign w_pick1 = req1 & (~req0 | ~r_last);

    always_comb begin
        w_state_next  = r_state;
        w_last_next   = r_last;
        w_cmd_rw_next = r_cmd_rw;
        w_gnt0_next   = 1'b0;
        w_gnt1_next   = 1'b0;
        w_done0_next  = 1'b0;
        w_done1_next  = 1'b0;
        w_rd_a_next   = r_rd_a;
        w_rd_b_next   = r_rd_b;
        w_rf_en_next  = 1'b0;
        w_rf_rw_next  = 2'b00;
        w_rf_da_next  = r_rf_da;
        w_rf_aa_next  = r_rf_aa;
        w_rf_ba_next  = r_rf_ba;
        w_rf_d_next   = r_rf_d;

        case (r_state)
            StIdle: begin
                if (req0 | req1) begin
                    w_state_next  = StIssue;
                    w_last_next   = w_pick1;
                    w_gnt0_next   = ~w_pick1;
                    w_gnt1_next   = w_pick1;
                    w_cmd_rw_next = w_pick1 ? rw1 : rw0;
                    w_rf_en_next  = 1'b1;
                    w_rf_rw_next  = w_pick1 ? rw1 : rw0;
                    w_rf_da_next  = w_pick1 ? da1 : da0;
                    w_rf_aa_next  = w_pick1 ? aa1 : aa0;
                    w_rf_ba_next  = w_pick1 ? ba1 : ba0;
                    w_rf_d_next   = w_pick1 ? d1 : d0;
                end
            end
            StIssue: begin
                w_state_next = StCapture;
            end
            StCapture: begin
                if (r_cmd_rw[1]) begin
                    w_rd_a_next = rf_a;
                    w_rd_b_next = rf_b;
                end
                w_done0_next = ~r_last;
                w_done1_next = r_last;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        w_busy_next = (w_state_next != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_last   <= 1'b1;
            r_cmd_rw <= 2'b00;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_rd_a   <= 16'h0000;
            r_rd_b   <= 16'h0000;
            r_busy   <= 1'b0;
            r_rf_en  <= 1'b0;
            r_rf_rw  <= 2'b00;
            r_rf_da  <= 4'h0;
            r_rf_aa  <= 4'h0;
            r_rf_ba  <= 4'h0;
            r_rf_d   <= 16'h0000;
        end else begin
            r_state  <= w_state_next;
            r_last   <= w_last_next;
            r_cmd_rw <= w_cmd_rw_next;
            r_gnt0   <= w_gnt0_next;
            r_gnt1   <= w_gnt1_next;
            r_done0  <= w_done0_next;
            r_done1  <= w_done1_next;
            r_rd_a   <= w_rd_a_next;
            r_rd_b   <= w_rd_b_next;
            r_busy   <= w_busy_next;
            r_rf_en  <= w_rf_en_next;
            r_rf_rw  <= w_rf_rw_next;
            r_rf_da  <= w_rf_da_next;
            r_rf_aa  <= w_rf_aa_next;
            r_rf_ba  <= w_rf_ba_next;
            r_rf_d   <= w_rf_d_next;
        end
    end

    assign gnt0  = r_gnt0;
    assign gnt1  = r_gnt1;
    assign done0 = r_done0;
    assign done1 = r_done1;
    assign rd_a  = r_rd_a;
    assign rd_b  = r_rd_b;
    assign busy  = r_busy;
    // The register file only clears when EN is high during reset.
    assign rf_en = r_rf_en | rst;
    assign rf_rw = r_rf_rw;
    assign rf_da = r_rf_da;
    assign rf_aa = r_rf_aa;
    assign rf_ba = r_rf_ba;
    assign rf_d  = r_rf_d;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: a behavioural register file plus a memory-array
// reference model of command results, driven with directed and random commands.
module tb_regfile_arbiter;

    logic        clk, rst;
    logic        req0, req1;
    logic [1:0]  rw0, rw1;
    logic [3:0]  da0, da1, aa0, aa1, ba0, ba1;
    logic [15:0] d0, d1;
    logic        gnt0, gnt1, done0, done1, busy, rf_en;
    logic [15:0] rd_a, rd_b, rf_d, rf_a, rf_b;
    logic [1:0]  rf_rw;
    logic [3:0]  rf_da, rf_aa, rf_ba;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] ref_mem [16];
    logic [15:0] exp_a, exp_b;
    int          m_last;

    regfile_arbiter u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .da0(da0), .da1(da1), .aa0(aa0), .aa1(aa1), .ba0(ba0), .ba1(ba1),
        .d0(d0), .d1(d1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rd_a(rd_a), .rd_b(rd_b), .busy(busy),
        .rf_en(rf_en), .rf_rw(rf_rw), .rf_da(rf_da), .rf_aa(rf_aa), .rf_ba(rf_ba),
        .rf_d(rf_d), .rf_a(rf_a), .rf_b(rf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: reads before writes on the same edge, clears when EN is high in reset.
    logic [15:0] rf_mem [16];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            if (rf_en) begin
                for (int i = 0; i < 16; i++) rf_mem[i] <= 16'h0000;
            end
            rf_a <= 16'h0000;
            rf_b <= 16'h0000;
        end else if (rf_en) begin
            if (rf_rw[1]) begin
                rf_a <= rf_mem[rf_aa];
                rf_b <= rf_mem[rf_ba];
            end
            if (rf_rw[0]) rf_mem[rf_da] <= rf_d;
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
        exp_a  = 16'h0000;
        exp_b  = 16'h0000;
        m_last = 1;
    endfunction

    function automatic void model_cmd(input logic [1:0] rw, input logic [3:0] da, aa, ba,
                                      input logic [15:0] d);
        if (rw[1]) begin
            exp_a = ref_mem[aa];
            exp_b = ref_mem[ba];
        end
        if (rw[0]) ref_mem[da] = d;
    endfunction

    function automatic logic gnt_of(input int c);
        return (c == 0) ? gnt0 : gnt1;
    endfunction

    function automatic logic done_of(input int c);
        return (c == 0) ? done0 : done1;
    endfunction

    task automatic set_cmd(input int c, input logic [1:0] rw, input logic [3:0] da, aa, ba,
                           input logic [15:0] d);
        if (c == 0) begin
            req0 = 1'b1; rw0 = rw; da0 = da; aa0 = aa; ba0 = ba; d0 = d;
        end else begin
            req1 = 1'b1; rw1 = rw; da1 = da; aa1 = aa; ba1 = ba; d1 = d;
        end
    endtask

    // Drops the request and scrambles the fields, which the DUT must already have latched.
    task automatic clear_req(input int c);
        if (c == 0) begin
            req0 = 1'b0; rw0 = 2'($urandom); da0 = 4'($urandom); aa0 = 4'($urandom);
            ba0 = 4'($urandom); d0 = 16'($urandom);
        end else begin
            req1 = 1'b0; rw1 = 2'($urandom); da1 = 4'($urandom); aa1 = 4'($urandom);
            ba1 = 4'($urandom); d1 = 16'($urandom);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Runs one command to completion; returns cycle counts (-1 on timeout) and observations.
    task automatic issue(input int c, input logic [1:0] rw, input logic [3:0] da, aa, ba,
                         input logic [15:0] d, output int g_cyc, output int d_cyc,
                         output logic [15:0] oa, output logic [15:0] ob,
                         output logic [1:0] iss_rw, output bit wr_seen);
        g_cyc = -1; d_cyc = -1; oa = rd_a; ob = rd_b; iss_rw = 2'b00; wr_seen = 1'b0;
        @(negedge clk);
        set_cmd(c, rw, da, aa, ba, d);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rf_rw == 2'b01) wr_seen = 1'b1;
            if (gnt_of(c)) begin
                g_cyc = k;
                break;
            end
        end
        clear_req(c);
        if (g_cyc < 0) return;
        iss_rw = rf_rw;
        model_cmd(rw, da, aa, ba, d);
        m_last = c;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rf_rw == 2'b01) wr_seen = 1'b1;
            if (done_of(c)) begin
                d_cyc = k;
                oa = rd_a;
                ob = rd_b;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int g, dn;
        logic [15:0] oa, ob;
        logic [1:0] irw;
        bit ws;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (rf_en !== 1'b1) begin
                n_errors++; $display("FAIL reset_rf_en: got %b, expected 1", rf_en);
            end
            n_checks++;
            if ({gnt0, gnt1, done0, done1, busy, rf_rw} !== 7'b0) begin
                n_errors++;
                $display("FAIL reset_ctrl: got %b, expected 0", {gnt0, gnt1, done0, done1, busy, rf_rw});
            end
        end
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (busy !== 1'b0 || rf_en !== 1'b0) begin
            n_errors++; $display("FAIL reset_release: busy=%b rf_en=%b, expected 0 0", busy, rf_en);
        end
        for (int i = 0; i < 8; i++) begin
            issue(0, 2'b10, 4'h0, 4'(i), 4'(i + 8), 16'h0, g, dn, oa, ob, irw, ws);
            n_checks++;
            if (oa !== exp_a || ob !== exp_b) begin
                n_errors++;
                $display("FAIL reset_read r%0d/r%0d: got %h %h, expected %h %h", i, i + 8, oa, ob,
                         exp_a, exp_b);
            end
        end
    endtask

    task automatic test_write_read();
        int g, dn;
        logic [15:0] oa, ob;
        logic [1:0] irw;
        bit ws;
        issue(0, 2'b01, 4'h5, 4'h0, 4'h0, 16'hA5C3, g, dn, oa, ob, irw, ws);
        n_checks++;
        if (g !== 1 || dn !== 2) begin
            n_errors++; $display("FAIL wr_timing: gnt %0d done %0d, expected 1 2", g, dn);
        end
        n_checks++;
        if (irw !== 2'b01) begin
            n_errors++; $display("FAIL wr_issue_rw: got %b, expected 01", irw);
        end
        issue(0, 2'b10, 4'h0, 4'h5, 4'h0, 16'h0, g, dn, oa, ob, irw, ws);
        n_checks++;
        if (g !== 1 || dn !== 2) begin
            n_errors++; $display("FAIL rd_timing: gnt %0d done %0d, expected 1 2", g, dn);
        end
        n_checks++;
        if (oa !== 16'hA5C3 || ob !== 16'h0000) begin
            n_errors++; $display("FAIL rd_data: got %h %h, expected a5c3 0000", oa, ob);
        end
    endtask

    task automatic test_tie();
        int gc[3];
        int gcyc[3];
        int ng = 0;
        bit next0 = 1'b0;
        bit got = 1'b0;
        logic [15:0] oa = 16'h0, ob = 16'h0;
        apply_reset();
        @(negedge clk);
        set_cmd(0, 2'b01, 4'h1, 4'h0, 4'h0, 16'h1111);
        set_cmd(1, 2'b01, 4'h2, 4'h0, 4'h0, 16'h2222);
        for (int cyc = 1; cyc <= 30 && !got; cyc++) begin
            @(negedge clk);
            if (done0 && ng == 3) begin
                got = 1'b1; oa = rd_a; ob = rd_b;
            end
            if (gnt0 && ng < 3) begin
                gc[ng] = 0; gcyc[ng] = cyc; ng++;
                if (!next0) begin
                    model_cmd(2'b01, 4'h1, 4'h0, 4'h0, 16'h1111);
                    set_cmd(0, 2'b10, 4'h0, 4'h1, 4'h2, 16'h0);
                    next0 = 1'b1;
                end else begin
                    model_cmd(2'b10, 4'h0, 4'h1, 4'h2, 16'h0);
                    clear_req(0);
                end
            end
            if (gnt1 && ng < 3) begin
                gc[ng] = 1; gcyc[ng] = cyc; ng++;
                model_cmd(2'b01, 4'h2, 4'h0, 4'h0, 16'h2222);
                clear_req(1);
            end
        end
        clear_req(0);
        clear_req(1);
        m_last = 0;
        n_checks++;
        if (ng !== 3) begin
            n_errors++; $display("FAIL tie_count: got %0d grants, expected 3", ng);
        end else begin
            n_checks++;
            if (gc[0] !== 0 || gc[1] !== 1 || gc[2] !== 0) begin
                n_errors++;
                $display("FAIL tie_order: got %0d,%0d,%0d expected 0,1,0", gc[0], gc[1], gc[2]);
            end
            n_checks++;
            if (gcyc[0] !== 1 || gcyc[1] - gcyc[0] !== 3 || gcyc[2] - gcyc[1] !== 3) begin
                n_errors++;
                $display("FAIL tie_spacing: got %0d,%0d,%0d expected 1,4,7", gcyc[0], gcyc[1], gcyc[2]);
            end
        end
        n_checks++;
        if (!got || oa !== 16'h1111 || ob !== 16'h2222 || oa !== exp_a || ob !== exp_b) begin
            n_errors++; $display("FAIL tie_read: got %h %h (done=%0d), expected 1111 2222", oa, ob, got);
        end
    endtask

    task automatic test_rw_same();
        int g, dn;
        logic [15:0] oa, ob;
        logic [1:0] irw;
        bit ws;
        issue(0, 2'b01, 4'h7, 4'h0, 4'h0, 16'h00FF, g, dn, oa, ob, irw, ws);
        issue(1, 2'b11, 4'h7, 4'h7, 4'h7, 16'hBEEF, g, dn, oa, ob, irw, ws);
        n_checks++;
        if (g !== 1 || dn !== 2 || oa !== 16'h00FF || ob !== exp_b) begin
            n_errors++;
            $display("FAIL rw_same: gnt %0d done %0d a=%h b=%h, expected 1 2 00ff %h", g, dn, oa, ob, exp_b);
        end
        issue(0, 2'b10, 4'h0, 4'h7, 4'h7, 16'h0, g, dn, oa, ob, irw, ws);
        n_checks++;
        if (oa !== 16'hBEEF || ob !== 16'hBEEF) begin
            n_errors++; $display("FAIL rw_same_after: got %h %h, expected beef beef", oa, ob);
        end
    endtask

    task automatic test_noop_withdraw();
        int g, dn;
        int g1 = 0;
        bit d0_seen = 1'b0;
        bit wr_any = 1'b0;
        logic [15:0] oa, ob, pa, pb;
        logic [1:0] irw;
        bit ws;
        pa = rd_a;
        pb = rd_b;
        issue(1, 2'b00, 4'h3, 4'h4, 4'h5, 16'hDEAD, g, dn, oa, ob, irw, ws);
        n_checks++;
        if (g !== 1 || dn !== 2 || irw !== 2'b00 || ws) begin
            n_errors++;
            $display("FAIL noop_seq: gnt %0d done %0d rw %b wr %0d, expected 1 2 00 0", g, dn, irw, ws);
        end
        n_checks++;
        if (oa !== pa || ob !== pb || oa !== exp_a) begin
            n_errors++; $display("FAIL noop_rd: got %h %h, expected %h %h", oa, ob, pa, pb);
        end
        @(negedge clk);
        set_cmd(0, 2'b10, 4'h0, 4'h7, 4'h3, 16'h0);
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b1) begin
            n_errors++; $display("FAIL wd_gnt0: got %b, expected 1", gnt0);
        end
        clear_req(0);
        model_cmd(2'b10, 4'h0, 4'h7, 4'h3, 16'h0);
        m_last = 0;
        set_cmd(1, 2'b01, 4'h3, 4'h0, 4'h0, 16'hDEAD);
        @(negedge clk);
        clear_req(1);
        for (int k = 0; k < 8; k++) begin
            if (gnt1) g1++;
            if (done0) begin
                d0_seen = 1'b1; oa = rd_a; ob = rd_b;
            end
            if (rf_rw == 2'b01) wr_any = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (g1 !== 0 || wr_any) begin
            n_errors++; $display("FAIL wd_gnt1: got %0d grants wr=%0d, expected 0 0", g1, wr_any);
        end
        n_checks++;
        if (!d0_seen || oa !== exp_a || ob !== exp_b) begin
            n_errors++;
            $display("FAIL wd_read: done=%0d got %h %h, expected %h %h", d0_seen, oa, ob, exp_a, exp_b);
        end
    endtask

    task automatic test_reset_mid();
        int g, dn;
        bit dseen = 1'b0;
        logic [15:0] oa, ob;
        logic [1:0] irw;
        bit ws;
        issue(0, 2'b01, 4'h9, 4'h0, 4'h0, 16'h1234, g, dn, oa, ob, irw, ws);
        issue(0, 2'b10, 4'h0, 4'h9, 4'h9, 16'h0, g, dn, oa, ob, irw, ws);
        n_checks++;
        if (oa !== 16'h1234) begin
            n_errors++; $display("FAIL mid_pre: got %h, expected 1234", oa);
        end
        @(negedge clk);
        set_cmd(0, 2'b10, 4'h0, 4'h9, 4'h9, 16'h0);
        @(negedge clk);
        clear_req(0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (rd_a !== 16'h0 || rd_b !== 16'h0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL mid_clear: rd %h %h busy %b, expected 0 0 0", rd_a, rd_b, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            if (done0 || done1 || gnt0 || gnt1) dseen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (dseen || busy !== 1'b0) begin
            n_errors++; $display("FAIL mid_done: pulse=%0d busy=%b, expected 0 0", dseen, busy);
        end
        issue(1, 2'b10, 4'h0, 4'h9, 4'h9, 16'h0, g, dn, oa, ob, irw, ws);
        n_checks++;
        if (g !== 1 || oa !== 16'h0 || ob !== 16'h0) begin
            n_errors++; $display("FAIL mid_after: gnt %0d got %h %h, expected 1 0000 0000", g, oa, ob);
        end
    endtask

    task automatic test_random();
        int g, dn, c;
        logic [15:0] oa, ob;
        logic [1:0] irw, rw;
        bit ws;
        for (int n = 0; n < 40; n++) begin
            c  = int'($urandom_range(1, 0));
            rw = 2'($urandom);
            issue(c, rw, 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom),
                  g, dn, oa, ob, irw, ws);
            n_checks++;
            if (g !== 1 || dn !== 2 || irw !== rw || ws !== (rw == 2'b01)) begin
                n_errors++;
                $display("FAIL rand_seq[%0d]: gnt %0d done %0d rw %b wr %0d, expected 1 2 %b %0d",
                         n, g, dn, irw, ws, rw, rw == 2'b01);
            end
            n_checks++;
            if (oa !== exp_a || ob !== exp_b) begin
                n_errors++;
                $display("FAIL rand_rd[%0d]: got %h %h, expected %h %h", n, oa, ob, exp_a, exp_b);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  c_rw [2];
        logic [3:0]  c_da [2], c_aa [2], c_ba [2];
        logic [15:0] c_d  [2];
        int          q_own [$];
        logic [15:0] q_a [$], q_b [$];
        int last_cyc = -1;
        int ngr = 0;
        int w, own;
        logic [15:0] ea, eb;
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            c_rw[c] = 2'($urandom); c_da[c] = 4'($urandom); c_aa[c] = 4'($urandom);
            c_ba[c] = 4'($urandom); c_d[c] = 16'($urandom);
            set_cmd(c, c_rw[c], c_da[c], c_aa[c], c_ba[c], c_d[c]);
        end
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            if (done0 || done1) begin
                n_checks++;
                if (q_own.size() == 0) begin
                    n_errors++; $display("FAIL b2b_done: unexpected done at cycle %0d", cyc);
                end else begin
                    own = q_own.pop_front(); ea = q_a.pop_front(); eb = q_b.pop_front();
                    if (done_of(own) !== 1'b1 || done_of(1 - own) !== 1'b0 ||
                        rd_a !== ea || rd_b !== eb) begin
                        n_errors++;
                        $display("FAIL b2b_done: done %b%b rd %h %h, expected owner %0d rd %h %h",
                                 done0, done1, rd_a, rd_b, own, ea, eb);
                    end
                end
            end
            if (gnt0 || gnt1) begin
                w = gnt1 ? 1 : 0;
                n_checks++;
                if ((gnt0 && gnt1) || w != 1 - m_last || (last_cyc >= 0 && cyc - last_cyc != 3)) begin
                    n_errors++;
                    $display("FAIL b2b_gnt: gnt %b%b at %0d (prev %0d), expected client %0d 3 apart",
                             gnt0, gnt1, cyc, last_cyc, 1 - m_last);
                end
                model_cmd(c_rw[w], c_da[w], c_aa[w], c_ba[w], c_d[w]);
                q_own.push_back(w); q_a.push_back(exp_a); q_b.push_back(exp_b);
                m_last = w;
                last_cyc = cyc;
                ngr++;
                c_rw[w] = 2'($urandom); c_da[w] = 4'($urandom); c_aa[w] = 4'($urandom);
                c_ba[w] = 4'($urandom); c_d[w] = 16'($urandom);
                set_cmd(w, c_rw[w], c_da[w], c_aa[w], c_ba[w], c_d[w]);
            end
            if (cyc == 40) begin
                clear_req(0);
                clear_req(1);
            end
        end
        n_checks++;
        if (ngr < 12 || q_own.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_total: %0d grants, %0d pending, expected >=12 and 0", ngr, q_own.size());
        end
    endtask

    initial begin
        rst = 1'b0;
        req0 = 1'b0; rw0 = 2'b00; da0 = 4'h0; aa0 = 4'h0; ba0 = 4'h0; d0 = 16'h0;
        req1 = 1'b0; rw1 = 2'b00; da1 = 4'h0; aa1 = 4'h0; ba1 = 4'h0; d1 = 16'h0;
        model_reset();
        #1 rst = 1'b1;
        test_reset();
        test_write_read();
        test_tie();
        test_rw_same();
        test_noop_withdraw();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
